// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - CPU/DMA arbiter for the single-port data memory
module dm_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [3:0]        cpu_be,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [31:0]       dma_addr,
    input  logic [3:0]        dma_be,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [31:0]       rdata,
    output logic              addr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    logic             valid_q, valid_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic        pick_dma;
    logic        any_gnt;
    logic        g_we;
    logic [31:0] g_addr;
    logic [3:0]  g_be;
    logic [31:0] g_wdata;

    always_comb begin
        pick_dma = dma_req & (~cpu_req | (starve_cnt_q == CNT_W'(STARVE_LIMIT)));
        // Grants are forced low while reset is held so every output reads 0.
        cpu_gnt   = cpu_req & ~pick_dma & ~reset;
        dma_gnt   = pick_dma & ~reset;
        cpu_stall = cpu_req & ~cpu_gnt & ~reset;
        any_gnt   = cpu_gnt | dma_gnt;

        g_we    = dma_gnt ? dma_we    : cpu_we;
        g_addr  = dma_gnt ? dma_addr  : cpu_addr;
        g_be    = dma_gnt ? dma_be    : cpu_be;
        g_wdata = dma_gnt ? dma_wdata : cpu_wdata;

        addr_err  = any_gnt & (|g_addr[31:ADDR_W+2]);
        mem_en    = any_gnt & ~addr_err;
        mem_we    = mem_en & g_we;
        mem_addr  = mem_en ? g_addr[ADDR_W+1:2] : '0;
        mem_be    = mem_we ? g_be : 4'b0000;
        mem_wdata = mem_we ? g_wdata : 32'h0;

        valid_d = mem_en & ~g_we;
        owner_d = dma_gnt;

        starve_cnt_d = starve_cnt_q;
        if (~dma_req | dma_gnt) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end

        cpu_rvalid = valid_q & ~owner_q;
        dma_rvalid = valid_q & owner_q;
        rdata      = reset ? 32'h0 : mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            owner_q      <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - directed bench for dm_port_arbiter with a word memory model
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [3:0]  cpu_be, dma_be;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] rdata;
    logic        addr_err, mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] mem [0:4095];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.ADDR_W(12), .STARVE_LIMIT(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_be(dma_be),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .rdata(rdata), .addr_err(addr_err), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                if (mem_be[0]) mem[mem_addr][7:0]   <= mem_wdata[7:0];
                if (mem_be[1]) mem[mem_addr][15:8]  <= mem_wdata[15:8];
                if (mem_be[2]) mem[mem_addr][23:16] <= mem_wdata[23:16];
                if (mem_be[3]) mem[mem_addr][31:24] <= mem_wdata[31:24];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wdata;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
        dma_req = req; dma_we = we; dma_addr = addr; dma_be = be; dma_wdata = wdata;
    endtask

    logic        prev_c, prev_d, exp_c;
    logic [31:0] a6 [4];
    logic        d6 [4];
    logic [31:0] e6 [4];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        mem[5] = 32'hCAFEF00D;
        mem[8] = 32'h11223344;
        reset = 1'b1;
        set_cpu(0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dma_gnt", dma_gnt, 0);
        chk("rst_rvalid", {cpu_rvalid, dma_rvalid}, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_addr_err", addr_err, 0);
        reset = 1'b0;

        // 1: CPU-only load of word 4
        @(negedge clk);
        set_cpu(1, 0, 32'h10, 4'hF, 0);
        #1;
        chk("t1_gnt", cpu_gnt, 1);
        chk("t1_stall", cpu_stall, 0);
        chk("t1_mem_en", {mem_en, mem_we}, 2'b10);
        chk("t1_mem_addr", mem_addr, 4);
        @(negedge clk);
        set_cpu(0, 0, 0, 0, 0);
        #1;
        chk("t1_cpu_rvalid", cpu_rvalid, 1);
        chk("t1_dma_rvalid", dma_rvalid, 0);
        chk("t1_rdata", rdata, 32'hDEADBEEF);

        // 2: both ports request continuously; DMA wins every 9th cycle
        prev_c = 0; prev_d = 0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            set_cpu(1, 0, 32'h10, 4'hF, 0);
            set_dma(1, 0, 32'h20, 4'hF, 0);
            #1;
            exp_c = (i % 9) != 0;
            chk($sformatf("t2_cpu_gnt_%0d", i), cpu_gnt, exp_c);
            chk($sformatf("t2_dma_gnt_%0d", i), dma_gnt, !exp_c);
            chk($sformatf("t2_stall_%0d", i), cpu_stall, !exp_c);
            chk($sformatf("t2_rvalid_%0d", i), {cpu_rvalid, dma_rvalid}, {prev_c, prev_d});
            prev_c = exp_c; prev_d = !exp_c;
        end
        @(negedge clk);
        set_cpu(0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0, 0);
        #1;
        chk("t2_last_rvalid", {cpu_rvalid, dma_rvalid}, 2'b01);
        chk("t2_last_rdata", rdata, 32'h11223344);

        // 3: DMA byte-lane store to misaligned 0x22, then read word 8 back
        @(negedge clk);
        set_dma(1, 1, 32'h22, 4'b0100, 32'h00AB0000);
        #1;
        chk("t3_dma_gnt", dma_gnt, 1);
        chk("t3_mem_we", {mem_en, mem_we}, 2'b11);
        chk("t3_mem_addr", mem_addr, 8);
        chk("t3_mem_be", mem_be, 4'b0100);
        chk("t3_mem_wdata", mem_wdata, 32'h00AB0000);
        @(negedge clk);
        set_dma(1, 0, 32'h20, 4'hF, 0);
        #1;
        chk("t3_store_no_rvalid", {cpu_rvalid, dma_rvalid}, 0);
        @(negedge clk);
        set_dma(0, 0, 0, 0, 0);
        #1;
        chk("t3_dma_rvalid", dma_rvalid, 1);
        chk("t3_rdata", rdata, 32'h11AB3344);

        // 4: out-of-range CPU load
        @(negedge clk);
        set_cpu(1, 0, 32'h4000, 4'hF, 0);
        #1;
        chk("t4_gnt", cpu_gnt, 1);
        chk("t4_addr_err", addr_err, 1);
        chk("t4_mem_en", mem_en, 0);
        @(negedge clk);
        set_cpu(0, 0, 0, 0, 0);
        #1;
        chk("t4_err_pulse", addr_err, 0);
        chk("t4_no_rvalid", cpu_rvalid, 0);

        // 5: reset lands between a load grant and its return edge
        @(negedge clk);
        set_cpu(1, 0, 32'h10, 4'hF, 0);
        #1;
        chk("t5_gnt", cpu_gnt, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("t5_rst_gnt", cpu_gnt, 0);
        chk("t5_rst_stall", cpu_stall, 0);
        chk("t5_rst_mem_en", mem_en, 0);
        chk("t5_rst_rdata", rdata, 0);
        @(negedge clk);
        set_cpu(0, 0, 0, 0, 0);
        #1;
        chk("t5_in_rst_rvalid", cpu_rvalid, 0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("t5_after_rvalid", {cpu_rvalid, dma_rvalid}, 0);

        // 6: alternating single-port loads; each return lands on its own port
        a6 = '{32'h10, 32'h14, 32'h20, 32'h10};
        d6 = '{1'b0, 1'b1, 1'b0, 1'b1};
        e6 = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h11AB3344, 32'hDEADBEEF};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                set_cpu(!d6[i], 0, a6[i], 4'hF, 0);
                set_dma(d6[i], 0, a6[i], 4'hF, 0);
            end else begin
                set_cpu(0, 0, 0, 0, 0);
                set_dma(0, 0, 0, 0, 0);
            end
            #1;
            if (i < 4) chk($sformatf("t6_gnt_%0d", i), {cpu_gnt, dma_gnt}, {!d6[i], d6[i]});
            if (i > 0) begin
                chk($sformatf("t6_rvalid_%0d", i), {cpu_rvalid, dma_rvalid}, {!d6[i-1], d6[i-1]});
                chk($sformatf("t6_rdata_%0d", i), rdata, e6[i-1]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
